core_immgen_pipe: RTL

- Registered, flow-controlled immediate-generation stage for the decode pipeline.
- Accepts a 32-bit instruction word and an opaque tag (typically the PC) over a valid/ready handshake.
- Produces the sign-extended immediate at XLEN width, a format code and an illegal flag one cycle later.
- A 2-entry skid buffer keeps in_ready registered, so there is no combinational ready path from the consumer.

---
 rtl/core_immgen_pipe.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/core_immgen_pipe.sv
// core_immgen_pipe
//   Registered, flow-controlled immediate-generation stage for the decode
//   pipeline. Each accepted instruction is decoded on entry and stored
//   already decoded, so both the main (M) and skid (S) registers hold final
//   results. in_ready comes straight from a flop; there is no combinational
//   path from out_ready to in_ready.
//
// Optional feature macro: CORE_IMMGEN_CSR_UIMM_EN
//   defined   : SYSTEM with ir[14]=1 yields fmt Z, imm = zero-extended ir[19:15]
//   undefined : every SYSTEM instruction yields fmt NONE, imm 0, not illegal
//
// Parameters
//   XLEN   datapath width (32 or 64); immediates are sign-extended to XLEN
//   TAG_W  width of the sideband tag
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous flush, drops all held entries
//   in_valid     upstream instruction valid
//   in_ready     stage can accept (registered)
//   in_ir        32-bit instruction word
//   in_tag       sideband tag
//   out_valid    result valid
//   out_ready    downstream accepts
//   out_imm      immediate, XLEN wide
//   out_fmt      0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z
//   out_illegal  unsupported opcode or ir[1:0] != 2'b11
//   out_tag      tag of the presented entry

module core_immgen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ir,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } state_t;

    localparam logic [4:0] OP_LOAD    = 5'b00000;
    localparam logic [4:0] OP_OPIMM   = 5'b00100;
    localparam logic [4:0] OP_AUIPC   = 5'b00101;
    localparam logic [4:0] OP_OPIMM32 = 5'b00110;
    localparam logic [4:0] OP_STORE   = 5'b01000;
    localparam logic [4:0] OP_LUI     = 5'b01101;
    localparam logic [4:0] OP_BRANCH  = 5'b11000;
    localparam logic [4:0] OP_JALR    = 5'b11001;
    localparam logic [4:0] OP_JAL     = 5'b11011;
    localparam logic [4:0] OP_SYSTEM  = 5'b11100;

    // ---------------------------------------------------------------
    // Decode of the incoming word
    // ---------------------------------------------------------------
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    fmt_t            w_fmt;
    logic            w_ill;

    always_comb begin
        w_imm32 = '0;
        w_fmt   = FMT_NONE;
        w_ill   = 1'b0;
        if (in_ir[1:0] != 2'b11) begin
            w_ill = 1'b1;
        end else begin
            unique case (in_ir[6:2])
                OP_OPIMM, OP_LOAD, OP_JALR: begin
                    w_fmt   = FMT_I;
                    w_imm32 = {{20{in_ir[31]}}, in_ir[31:20]};
                end
                OP_STORE: begin
                    w_fmt   = FMT_S;
                    w_imm32 = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
                end
                OP_BRANCH: begin
                    w_fmt   = FMT_B;
                    w_imm32 = {{19{in_ir[31]}}, in_ir[31], in_ir[7],
                               in_ir[30:25], in_ir[11:8], 1'b0};
                end
                OP_LUI, OP_AUIPC: begin
                    w_fmt   = FMT_U;
                    w_imm32 = {in_ir[31:12], 12'b0};
                end
                OP_JAL: begin
                    w_fmt   = FMT_J;
                    w_imm32 = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12],
                               in_ir[20], in_ir[30:21], 1'b0};
                end
                OP_OPIMM32: begin
                    if (XLEN == 64) begin
                        w_fmt   = FMT_I;
                        w_imm32 = {{20{in_ir[31]}}, in_ir[31:20]};
                    end else begin
                        w_ill = 1'b1;
                    end
                end
                OP_SYSTEM: begin
`ifdef CORE_IMMGEN_CSR_UIMM_EN
                    if (in_ir[14]) begin
                        w_fmt   = FMT_Z;
                        w_imm32 = {27'b0, in_ir[19:15]};
                    end
`endif
                end
                default: w_ill = 1'b1;
            endcase
        end
    end

    // Every 32-bit immediate above is already correctly signed (Z has bit 31
    // clear), so a single sign-extension covers both XLEN=32 and XLEN=64.
    assign w_imm = XLEN'($signed(w_imm32));

    // ---------------------------------------------------------------
    // Two-entry skid pipeline
    // ---------------------------------------------------------------
    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [XLEN-1:0]  r_m_imm,  r_s_imm;
    fmt_t             r_m_fmt,  r_s_fmt;
    logic             r_m_ill,  r_s_ill;
    logic [TAG_W-1:0] r_m_tag,  r_s_tag;

    logic w_acc;
    logic w_drn;

    assign w_acc = in_valid && r_in_ready;
    assign w_drn = r_out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_m_imm     <= '0;
            r_m_fmt     <= FMT_NONE;
            r_m_ill     <= 1'b0;
            r_m_tag     <= '0;
            r_s_imm     <= '0;
            r_s_fmt     <= FMT_NONE;
            r_s_ill     <= 1'b0;
            r_s_tag     <= '0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        r_m_imm     <= w_imm;
                        r_m_fmt     <= w_fmt;
                        r_m_ill     <= w_ill;
                        r_m_tag     <= in_tag;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_drn) begin
                        r_m_imm <= w_imm;
                        r_m_fmt <= w_fmt;
                        r_m_ill <= w_ill;
                        r_m_tag <= in_tag;
                    end else if (w_acc) begin
                        r_s_imm    <= w_imm;
                        r_s_fmt    <= w_fmt;
                        r_s_ill    <= w_ill;
                        r_s_tag    <= in_tag;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_TWO;
                    end else if (w_drn) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_drn) begin
                        r_m_imm    <= r_s_imm;
                        r_m_fmt    <= r_s_fmt;
                        r_m_ill    <= r_s_ill;
                        r_m_tag    <= r_s_tag;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_imm     = r_m_imm;
    assign out_fmt     = r_m_fmt;
    assign out_illegal = r_m_ill;
    assign out_tag     = r_m_tag;

endmodule
